// File: rtl/leaf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : leaf_pkg
// Brief   : Shared BFT leaf packet layout, default widths and packing helper.
// Revision: 1.0
// ============================================================================
package leaf_pkg;

    localparam int c_PAYLOAD_BITS   = 32;
    localparam int c_NUM_LEAF_BITS  = 5;
    localparam int c_NUM_PORT_BITS  = 4;
    localparam int c_NUM_ADDR_BITS  = 7;
    localparam int c_INIT_CREDITS   = 64;

    // Field offsets for the default layout, LSB upward: payload, seq, port, leaf, valid
    localparam int c_PKT_PAYLOAD_LSB = 0;
    localparam int c_PKT_SEQ_LSB     = c_PKT_PAYLOAD_LSB + c_PAYLOAD_BITS;
    localparam int c_PKT_DPORT_LSB   = c_PKT_SEQ_LSB + c_NUM_ADDR_BITS;
    localparam int c_PKT_DLEAF_LSB   = c_PKT_DPORT_LSB + c_NUM_PORT_BITS;
    localparam int c_PKT_VALID_BIT   = c_PKT_DLEAF_LSB + c_NUM_LEAF_BITS;
    localparam int c_PACKET_BITS     = c_PKT_VALID_BIT + 1;

    typedef struct packed {
        logic                       valid;
        logic [c_NUM_LEAF_BITS-1:0] dst_leaf;
        logic [c_NUM_PORT_BITS-1:0] dst_port;
        logic [c_NUM_ADDR_BITS-1:0] seq;
        logic [c_PAYLOAD_BITS-1:0]  payload;
    } packet_t;

    function automatic packet_t pack_packet(
        input logic [c_NUM_LEAF_BITS-1:0] dst_leaf,
        input logic [c_NUM_PORT_BITS-1:0] dst_port,
        input logic [c_NUM_ADDR_BITS-1:0] seq,
        input logic [c_PAYLOAD_BITS-1:0]  payload
    );
        packet_t pkt;
        pkt.valid    = 1'b1;
        pkt.dst_leaf = dst_leaf;
        pkt.dst_port = dst_port;
        pkt.seq      = seq;
        pkt.payload  = payload;
        return pkt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin arbiter with one-hot grant and next pointer.
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int PTR_BITS = 2
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [PTR_BITS-1:0] i_ptr,
    output logic [NUM_REQ-1:0]  o_grant,
    output logic [PTR_BITS-1:0] o_grant_idx,
    output logic                o_grant_vld,
    output logic [PTR_BITS-1:0] o_next_ptr
);

    int w_cand;

    // Scan from the pointer, wrapping modulo NUM_REQ; the first requester wins
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_vld = 1'b0;
        w_cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = int'(i_ptr) + i;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (!o_grant_vld && i_req[w_cand]) begin
                o_grant_vld     = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_grant_idx     = PTR_BITS'(w_cand);
            end
        end
    end

    assign o_next_ptr = !o_grant_vld                              ? i_ptr :
                        (int'(o_grant_idx) == NUM_REQ - 1)        ? '0    :
                                                                    o_grant_idx + 1'b1;

endmodule
`default_nettype wire

// File: rtl/leaf_out_packetizer.sv
`default_nettype none
// ============================================================================
// Module  : leaf_out_packetizer
// Brief   : Credit-gated round-robin packetizer from user outputs to the BFT.
// Revision: 1.0
// ============================================================================
module leaf_out_packetizer
    import leaf_pkg::*;
#(
    parameter int PAYLOAD_BITS  = c_PAYLOAD_BITS,
    parameter int NUM_LEAF_BITS = c_NUM_LEAF_BITS,
    parameter int NUM_PORT_BITS = c_NUM_PORT_BITS,
    parameter int NUM_ADDR_BITS = c_NUM_ADDR_BITS,
    parameter int PACKET_BITS   = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS,
    parameter int NUM_OUT_PORTS = 4,
    parameter int CREDIT_BITS   = 8,
    parameter int INIT_CREDITS  = c_INIT_CREDITS
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]          vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]          ack_interface2user,
    input  logic                              cfg_wr,
    input  logic [NUM_PORT_BITS-1:0]          cfg_port,
    input  logic [NUM_LEAF_BITS-1:0]          cfg_dst_leaf,
    input  logic [NUM_PORT_BITS-1:0]          cfg_dst_port,
    input  logic                              credit_vld,
    input  logic [NUM_PORT_BITS-1:0]          credit_port,
    input  logic [CREDIT_BITS-1:0]            credit_amt,
    input  logic                              resend,
    output logic [PACKET_BITS-1:0]            dout_leaf_interface2bft,
    output logic                              err_credit_ovf
);

    localparam int c_PTR_BITS = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
    localparam logic [CREDIT_BITS-1:0] c_CREDIT_MAX = '1;

    logic [NUM_OUT_PORTS-1:0] w_req;
    logic [NUM_OUT_PORTS-1:0] w_grant;
    logic [NUM_OUT_PORTS-1:0] w_ovf;
    logic [c_PTR_BITS-1:0]    w_grant_idx;
    logic                     w_grant_vld;
    logic [c_PTR_BITS-1:0]    w_next_ptr;
    logic [c_PTR_BITS-1:0]    r_rr_ptr;
    logic [PACKET_BITS-1:0]   r_dout;
    logic                     r_err;

    logic [NUM_LEAF_BITS-1:0] w_dst_leaf [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] w_dst_port [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] w_seq      [NUM_OUT_PORTS];
    logic [PAYLOAD_BITS-1:0]  w_data     [NUM_OUT_PORTS];

    for (genvar p = 0; p < NUM_OUT_PORTS; p++) begin : g_port
        logic                     r_cfg_valid;
        logic [NUM_LEAF_BITS-1:0] r_dst_leaf;
        logic [NUM_PORT_BITS-1:0] r_dst_port;
        logic [NUM_ADDR_BITS-1:0] r_seq;
        logic [CREDIT_BITS-1:0]   r_credit;
        logic                     w_cfg_hit;
        logic                     w_credit_hit;
        logic [CREDIT_BITS:0]     w_sum;

        assign w_cfg_hit    = cfg_wr && (cfg_port == NUM_PORT_BITS'(p));
        assign w_credit_hit = credit_vld && (credit_port == NUM_PORT_BITS'(p));

        // Grant implies credit >= 1, so the net sum never underflows; the carry flags saturation
        assign w_sum    = {1'b0, r_credit}
                        + (w_credit_hit ? {1'b0, credit_amt} : '0)
                        - {{CREDIT_BITS{1'b0}}, w_grant[p]};
        assign w_ovf[p] = w_sum[CREDIT_BITS];

        assign w_req[p]      = reset_n && !resend && vld_user2interface[p] && r_cfg_valid
                            && (r_credit != '0);
        assign w_dst_leaf[p] = r_dst_leaf;
        assign w_dst_port[p] = r_dst_port;
        assign w_seq[p]      = r_seq;
        assign w_data[p]     = din_leaf_user2interface[p*PAYLOAD_BITS +: PAYLOAD_BITS];

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_cfg_valid <= 1'b0;
                r_dst_leaf  <= '0;
                r_dst_port  <= '0;
                r_seq       <= '0;
                r_credit    <= CREDIT_BITS'(INIT_CREDITS);
            end else begin
                if (w_cfg_hit) begin
                    r_cfg_valid <= 1'b1;
                    r_dst_leaf  <= cfg_dst_leaf;
                    r_dst_port  <= cfg_dst_port;
                end
                r_credit <= w_ovf[p] ? c_CREDIT_MAX : w_sum[CREDIT_BITS-1:0];
                if (w_grant[p]) begin
                    r_seq <= r_seq + 1'b1;
                end
            end
        end
    end

    rr_arbiter #(
        .NUM_REQ  (NUM_OUT_PORTS),
        .PTR_BITS (c_PTR_BITS)
    ) u_rr_arbiter (
        .i_req       (w_req),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_vld (w_grant_vld),
        .o_next_ptr  (w_next_ptr)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
            r_dout   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rr_ptr <= w_next_ptr;
            if (w_grant_vld) begin
                r_dout <= {1'b1, w_dst_leaf[w_grant_idx], w_dst_port[w_grant_idx],
                           w_seq[w_grant_idx], w_data[w_grant_idx]};
            end else begin
                r_dout <= '0;
            end
            if (|w_ovf) begin
                r_err <= 1'b1;
            end
        end
    end

    assign ack_interface2user      = w_grant;
    // Freeze also hides a packet that was registered on the previous edge
    assign dout_leaf_interface2bft = resend ? '0 : r_dout;
    assign err_credit_ovf          = r_err;

endmodule
`default_nettype wire
